// File: rtl/anim_sequencer.sv
// anim_sequencer: debounced start/pause keys driving a 12-frame animation
// sequencer (cat 0-3, dog 0-3, mouse 0-3) for the dot-matrix driver.
// Optional macro ANIM_SEQ_LOOP_EN: when defined the sequence wraps from
// frame 11 back to frame 0 and keeps running instead of returning to IDLE.
module anim_sequencer #(
   parameter int TICK_DIV = 1000,
   parameter int TICK_W   = 10,
   parameter int DEB_CYC  = 20,
   parameter int DEB_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start,
   input  logic       key_pause,
   output logic [3:0] mode,
   output logic       running,
   output logic       step_pulse,
   output logic       seq_done
);

   localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEB_CYC);
   localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [3:0]        LAST_FRAME = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   // Key path state: bit 0 = start key, bit 1 = pause key.
   logic [1:0]       sync1_r;
   logic [1:0]       sync2_r;
   logic [1:0]       level_r;
   logic [1:0]       level_d_r;
   logic [DEB_W-1:0] deb_cnt_r [2];
   logic [1:0]       press_s;
   logic             start_p;
   logic             pause_p;

   state_t           state_r;
   logic [TICK_W-1:0] tick_cnt_r;
   logic             tick_s;
   logic             last_frame_s;

   // Synchronize the raw keys, debounce them and remember the previous level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r   <= 2'b00;
         sync2_r   <= 2'b00;
         level_r   <= 2'b00;
         level_d_r <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_r[i] <= '0;
         end
      end else begin
         sync1_r   <= {key_pause, key_start};
         sync2_r   <= sync1_r;
         level_d_r <= level_r;
         for (int i = 0; i < 2; i++) begin
            if (deb_cnt_r[i] == DEB_MAX) begin
               // Enough consecutive differing samples collected: accept.
               level_r[i]   <= ~level_r[i];
               deb_cnt_r[i] <= '0;
            end else if (sync2_r[i] != level_r[i]) begin
               deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
            end else begin
               deb_cnt_r[i] <= '0;
            end
         end
      end
   end

   // Press pulses on 0->1 debounced transitions; frame-step and end detection.
   always_comb begin
      press_s      = level_r & ~level_d_r;
      start_p      = press_s[0];
      pause_p      = press_s[1];
      tick_s       = (state_r == ST_RUN) && (tick_cnt_r == TICK_LAST);
      last_frame_s = (mode == LAST_FRAME);
   end

   // Sequencer FSM with registered outputs; running tracks the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         mode       <= 4'd0;
         tick_cnt_r <= '0;
         running    <= 1'b0;
         step_pulse <= 1'b0;
         seq_done   <= 1'b0;
      end else begin
         step_pulse <= 1'b0;
         seq_done   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               tick_cnt_r <= '0;
               if (start_p) begin
                  state_r <= ST_RUN;
                  mode    <= 4'd0;
                  running <= 1'b1;
               end else begin
                  running <= 1'b0;
               end
            end
            ST_RUN: begin
               if (start_p) begin
                  // Restart wins over a coinciding tick or pause.
                  mode       <= 4'd0;
                  tick_cnt_r <= '0;
                  running    <= 1'b1;
               end else if (tick_s) begin
                  tick_cnt_r <= '0;
                  if (!last_frame_s) begin
                     mode       <= mode + 4'd1;
                     step_pulse <= 1'b1;
                     if (pause_p) begin
                        state_r <= ST_PAUSE;
                        running <= 1'b0;
                     end else begin
                        running <= 1'b1;
                     end
                  end else begin
                     seq_done <= 1'b1;
`ifdef ANIM_SEQ_LOOP_EN
                     mode       <= 4'd0;
                     step_pulse <= 1'b1;
                     if (pause_p) begin
                        state_r <= ST_PAUSE;
                        running <= 1'b0;
                     end else begin
                        running <= 1'b1;
                     end
`else
                     // Last frame stays on display after the one-shot run.
                     state_r <= ST_IDLE;
                     running <= 1'b0;
`endif
                  end
               end else if (pause_p) begin
                  state_r <= ST_PAUSE;
                  running <= 1'b0;
               end else begin
                  tick_cnt_r <= tick_cnt_r + TICK_ONE;
                  running    <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (start_p) begin
                  state_r    <= ST_RUN;
                  mode       <= 4'd0;
                  tick_cnt_r <= '0;
                  running    <= 1'b1;
               end else if (pause_p) begin
                  // Resume with the partial frame time preserved.
                  state_r <= ST_RUN;
                  running <= 1'b1;
               end else begin
                  running <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               mode       <= 4'd0;
               tick_cnt_r <= '0;
               running    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer with TICK_DIV=4, DEB_CYC=3.
// A clean key press driven just after edge k is acted on by the FSM at edge k+7.
module tb_anim_sequencer;

   logic       clk;
   logic       rst;
   logic       key_start;
   logic       key_pause;
   logic [3:0] mode;
   logic       running;
   logic       step_pulse;
   logic       seq_done;

   int checks;
   int errors;

   typedef struct {
      int         adv;
      logic       r;
      logic       ks;
      logic       kp;
      logic [3:0] m;
      logic       run;
      logic       st;
      logic       dn;
      string      name;
   } vec_t;

   vec_t vt[$];

   anim_sequencer #(
      .TICK_DIV (4),
      .TICK_W   (3),
      .DEB_CYC  (3),
      .DEB_W    (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_start  (key_start),
      .key_pause  (key_pause),
      .mode       (mode),
      .running    (running),
      .step_pulse (step_pulse),
      .seq_done   (seq_done)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] m, input logic r,
                      input logic s, input logic d);
      checks++;
      if ({mode, running, step_pulse, seq_done} !== {m, r, s, d}) begin
         errors++;
         $display("FAIL %s: got mode=%b run=%b step=%b done=%b, expected mode=%b run=%b step=%b done=%b",
                  name, mode, running, step_pulse, seq_done, m, r, s, d);
      end
   endtask

   function automatic void addv(input int a, input logic r, input logic ks,
                                input logic kp, input logic [3:0] m,
                                input logic run, input logic st, input logic dn,
                                input string nm);
      vec_t v;
      v.adv = a; v.r = r; v.ks = ks; v.kp = kp;
      v.m = m; v.run = run; v.st = st; v.dn = dn; v.name = nm;
      vt.push_back(v);
   endfunction

   // Stimulus and checking.
   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      key_start = 1'b0;
      key_pause = 1'b0;

      // Reset with both keys held, then released: nothing starts.
      addv(2,  1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, "reset");
      addv(10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "no_start_after_reset");
      // Two-cycle press is rejected.
      addv(2,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "short_press");
      addv(10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "short_reject");
      // Bouncing every cycle never starts.
      for (int i = 0; i < 10; i++) begin
         addv(1, 1'b0, (i % 2 == 0), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "bounce");
      end
      // Steady high: start acted on 7 edges after drive (edge S).
      addv(6, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "bounce_settle");
      addv(1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "start_run");
      addv(3, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "frame0_hold");
      addv(1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, "step_1");
      for (int n = 2; n <= 11; n++) begin
         addv(1, 1'b0, 1'b0, 1'b0, 4'(n - 1), 1'b1, 1'b0, 1'b0, "frame_hold");
         addv(3, 1'b0, 1'b0, 1'b0, 4'(n),     1'b1, 1'b1, 1'b0, "frame_step");
      end
      addv(1, 1'b0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0, "last_hold");
`ifdef ANIM_SEQ_LOOP_EN
      addv(3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, "wrap");
      addv(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "after_wrap");
`else
      addv(3, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b1, "seq_done");
      addv(1, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 1'b0, "after_done");
`endif

      foreach (vt[i]) begin
         rst       = vt[i].r;
         key_start = vt[i].ks;
         key_pause = vt[i].kp;
         adv(vt[i].adv);
         chk(vt[i].name, vt[i].m, vt[i].run, vt[i].st, vt[i].dn);
      end

      // Pause/resume: new start lands at edge T.
      key_start = 1'b1;
      adv(7);  chk("restart_run", 4'd0, 1'b1, 1'b0, 1'b0);          // T
      adv(1);  key_start = 1'b0;                                     // T+1
      adv(15); chk("pre_pause", 4'd4, 1'b1, 1'b1, 1'b0);             // T+16
      key_pause = 1'b1;
      adv(7);  chk("paused", 4'd5, 1'b0, 1'b0, 1'b0);                // T+23, count 2
      adv(1);  key_pause = 1'b0;                                     // T+24
      adv(49); chk("frozen", 4'd5, 1'b0, 1'b0, 1'b0);                // T+73
      key_pause = 1'b1;
      adv(6);  key_start = 1'b1;                                     // T+79
      adv(1);  chk("resumed", 4'd5, 1'b1, 1'b0, 1'b0);               // T+80
      adv(1);  key_pause = 1'b0;
      chk("resume_cnt3", 4'd5, 1'b1, 1'b0, 1'b0);                    // T+81
      adv(1);  chk("resume_step", 4'd6, 1'b1, 1'b1, 1'b0);           // T+82
      // Restart coinciding with the tick out of frame 6.
      adv(3);  chk("pre_restart", 4'd6, 1'b1, 1'b0, 1'b0);           // T+85
      adv(1);  chk("restart_on_tick", 4'd0, 1'b1, 1'b0, 1'b0);       // T+86
      adv(1);  key_start = 1'b0;
      chk("restart_hold", 4'd0, 1'b1, 1'b0, 1'b0);                   // T+87
      adv(2);  chk("restart_cnt", 4'd0, 1'b1, 1'b0, 1'b0);           // T+89
      adv(1);  chk("restart_step", 4'd1, 1'b1, 1'b1, 1'b0);          // T+90
      // Start and pause pressed together: restart only.
      adv(4);                                                         // T+94
      key_start = 1'b1;
      key_pause = 1'b1;
      adv(7);  chk("collision", 4'd0, 1'b1, 1'b0, 1'b0);             // T+101
      adv(1);  key_start = 1'b0; key_pause = 1'b0;                   // T+102
      adv(2);  chk("collision_cnt", 4'd0, 1'b1, 1'b0, 1'b0);         // T+104
      adv(1);  chk("collision_step", 4'd1, 1'b1, 1'b1, 1'b0);        // T+105
      // Mid-run reset at frame 9.
      adv(32); chk("mode9", 4'd9, 1'b1, 1'b1, 1'b0);                 // T+137
      adv(1);  rst = 1'b1;
      adv(1);  chk("mid_reset", 4'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      adv(12); chk("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
